// File: rtl/clk_divide10w4_if.sv
// clk_divide10w4_if: divided-clock outputs of clk_divide10w4.
// Macro CLKDIV10W4_TICK_EN adds the clk10_tick pulse.
interface clk_divide10w4_if;
   logic clk10;
`ifdef CLKDIV10W4_TICK_EN
   logic clk10_tick;
   modport master (output clk10, output clk10_tick);
   modport slave  (input clk10, input clk10_tick);
`else
   modport master (output clk10);
   modport slave  (input clk10);
`endif
endinterface

// File: rtl/clk_divide10w4.sv
// clk_divide10w4: registered divide-by-DIV waveform, high HIGH cycles per period.
// Macro CLKDIV10W4_TICK_EN adds a one-cycle clk10_tick on each clk10 rise.
module clk_divide10w4 #(
   parameter int DIV  = 10,
   parameter int HIGH = 4
) (
   input logic clk,
   input logic rst,
   clk_divide10w4_if.master div
);
   localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   localparam logic [W-1:0] HI   = W'(HIGH);

   if (DIV < 2 || HIGH < 1 || HIGH > DIV - 1) begin : g_bad_params
      $error("clk_divide10w4: illegal DIV=%0d HIGH=%0d", DIV, HIGH);
   end

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         div.clk10 <= 1'b0;
      end else begin
         cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
         div.clk10 <= cnt < HI;
      end
   end

`ifdef CLKDIV10W4_TICK_EN
   // cnt==0 is exactly the edge where clk10 goes 0->1
   always_ff @(posedge clk) begin
      if (rst) div.clk10_tick <= 1'b0;
      else     div.clk10_tick <= cnt == '0;
   end
`endif
endmodule

// File: tb/tb_clk_divide10w4.sv
// tb_clk_divide10w4: directed checks of clk_divide10w4 at DIV/HIGH = 10/4, 3/1, 16/15.
// Macro CLKDIV10W4_TICK_EN also checks clk10_tick.
module tb_clk_divide10w4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   dv[3] = '{10, 3, 16};
   int   hv[3] = '{4, 1, 15};
   logic [2:0] s;

   always #5 clk = ~clk;

   clk_divide10w4_if if0 ();
   clk_divide10w4_if if3 ();
   clk_divide10w4_if if16 ();

   clk_divide10w4 u0 (.clk(clk), .rst(rst), .div(if0));
   clk_divide10w4 #(.DIV(3), .HIGH(1)) u3 (.clk(clk), .rst(rst), .div(if3));
   clk_divide10w4 #(.DIV(16), .HIGH(15)) u16 (.clk(clk), .rst(rst), .div(if16));

   assign s = {if16.clk10, if3.clk10, if0.clk10};

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < 3; i++) check($sformatf("%s_clk10_d%0d", tag, dv[i]), int'(s[i]), 0);
`ifdef CLKDIV10W4_TICK_EN
      check($sformatf("%s_tick", tag), int'(if0.clk10_tick), 0);
`endif
   endtask

   // cycle n counts negedges after the first edge with rst=0 (n=1 -> cnt was 0)
   task automatic run(input int cycles, input int glitch_at);
      int   last_rise[3];
      int   last_fall[3];
      logic prev[3];
      for (int i = 0; i < 3; i++) begin
         last_rise[i] = -1;
         last_fall[i] = -1;
         prev[i] = 1'b0;
      end
      for (int n = 1; n <= cycles; n++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check($sformatf("wave_d%0d_n%0d", dv[i], n), int'(s[i]), int'(((n - 1) % dv[i]) < hv[i]));
            if (s[i] && !prev[i]) begin
               if (last_rise[i] >= 0) check($sformatf("period_d%0d_n%0d", dv[i], n), n - last_rise[i], dv[i]);
               if (last_fall[i] >= 0) check($sformatf("low_d%0d_n%0d", dv[i], n), n - last_fall[i], dv[i] - hv[i]);
               last_rise[i] = n;
            end
            if (!s[i] && prev[i]) begin
               check($sformatf("high_d%0d_n%0d", dv[i], n), n - last_rise[i], hv[i]);
               last_fall[i] = n;
            end
            prev[i] = s[i];
         end
`ifdef CLKDIV10W4_TICK_EN
         check($sformatf("tick_n%0d", n), int'(if0.clk10_tick), int'(((n - 1) % 10) == 0));
`endif
         if (n == glitch_at) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end
   endtask

   initial begin
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_reset($sformatf("reset_c%0d", c));
      end
      rst = 1'b0;
      run(100, 47);
      // extra cycles: n=101,102 are the first two high cycles of u0
      for (int n = 101; n <= 102; n++) begin
         @(negedge clk);
         check($sformatf("pre_midrst_n%0d", n), int'(s[0]), 1);
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      run(48, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
